// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: per-domain clock-gate enable controller with serialized wake-up and idle hysteresis.
// Optional macro CLK_GATE_CTRL_STATS_EN adds per-domain gated-cycle counters (GATED_CNT, STATS_CLR).

module clk_gate_dom #(
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic busy,
  input  logic force_on,
  input  logic grant,
  output logic is_pend,
  output logic wake_hold,
  output logic wake_nxt,
  output logic clk_en,
  output logic ack
);
  localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {S_OFF, S_PEND, S_WAKE, S_ON, S_IDLE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d, ack_q, ack_d, fsm_ack;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fsm_ack = 1'b0;
    case (state_q)
      S_OFF:  if (req) state_d = S_PEND;
      S_PEND: begin
        if (grant) begin
          state_d = S_WAKE;
          cnt_d   = WAKE_LD;
        end else if (!req && !force_on) begin
          state_d = S_OFF;
        end
      end
      S_WAKE: begin
        // REQ is ignored here: a started wake always completes
        if (cnt_q == '0) begin
          state_d = S_ON;
          fsm_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ON: begin
        if (!req && !busy) begin
          state_d = S_IDLE;
          cnt_d   = IDLE_LD;
        end else begin
          fsm_ack = req;
        end
      end
      S_IDLE: begin
        if (req) begin
          state_d = S_ON;
          cnt_d   = '0;
          fsm_ack = 1'b1;
        end else if (busy) begin
          state_d = S_ON;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!force_on) begin
          state_d = S_OFF;
        end
      end
      default: state_d = S_OFF;
    endcase
    en_d  = force_on | (state_d inside {S_WAKE, S_ON, S_IDLE});
    ack_d = force_on ? req : fsm_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
    end
  end

  assign is_pend   = (state_q == S_PEND);
  // a domain on its last WAKE cycle frees the arbiter so the next wake has no bubble
  assign wake_hold = (state_q == S_WAKE) && (cnt_q != '0);
  assign wake_nxt  = (state_d == S_WAKE);
  assign clk_en    = en_q;
  assign ack       = ack_q;
endmodule

module clk_gate_ctrl #(
  parameter int N           = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   REQ,
  input  logic [N-1:0]   BUSY,
  input  logic           FORCE_ON,
`ifdef CLK_GATE_CTRL_STATS_EN
  input  logic           STATS_CLR,
  output logic [N*16-1:0] GATED_CNT,
`endif
  output logic [N-1:0]   CLK_EN,
  output logic [N-1:0]   ACK,
  output logic           WAKE_BUSY
);
  logic [N-1:0] is_pend, wake_hold, wake_nxt, cand, grant;
  logic         found, wake_busy_d, wake_busy_q;

  // fixed-priority wake arbiter: lowest-index PEND domain that still wants its clock
  assign cand = is_pend & (REQ | {N{FORCE_ON}});

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (cand[i] && !found && !(|wake_hold)) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    wake_busy_d = |wake_nxt;
  end

  for (genvar i = 0; i < N; i++) begin : g_dom
    clk_gate_dom #(
      .WAKE_CYCLES(WAKE_CYCLES),
      .IDLE_CYCLES(IDLE_CYCLES),
      .CNT_W      (CNT_W)
    ) u_dom (
      .clk      (CLK),
      .rst_n    (RST),
      .req      (REQ[i]),
      .busy     (BUSY[i]),
      .force_on (FORCE_ON),
      .grant    (grant[i]),
      .is_pend  (is_pend[i]),
      .wake_hold(wake_hold[i]),
      .wake_nxt (wake_nxt[i]),
      .clk_en   (CLK_EN[i]),
      .ack      (ACK[i])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) wake_busy_q <= 1'b0;
    else      wake_busy_q <= wake_busy_d;
  end

  assign WAKE_BUSY = wake_busy_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [N-1:0][15:0] gcnt_q, gcnt_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      gcnt_d[i] = gcnt_q[i];
      if (STATS_CLR)
        gcnt_d[i] = '0;
      else if (!CLK_EN[i] && gcnt_q[i] != 16'hFFFF)
        gcnt_d[i] = gcnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) gcnt_q <= '0;
    else      gcnt_q <= gcnt_d;
  end

  assign GATED_CNT = gcnt_q;
`endif
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: directed timing scenarios plus randomized traffic against a
// cycle-level reference model built from the domain lifecycle rules.

module tb_clk_gate_ctrl;
  localparam int N  = 4;
  localparam int WC = 2;
  localparam int IC = 8;
  localparam int P_OFF = 0, P_PEND = 1, P_WAKE = 2, P_ON = 3, P_IDLE = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         FORCE_ON = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] BUSY = '0;
  logic [N-1:0] CLK_EN, ACK;
  logic         WAKE_BUSY;
`ifdef CLK_GATE_CTRL_STATS_EN
  logic           STATS_CLR = 1'b0;
  logic [N*16-1:0] GATED_CNT;
  int             m_gc[N];
`endif

  int tests_run = 0;
  int fails = 0;

  // reference model: lifecycle phase per domain and cycles remaining in a timed phase
  int           ph[N];
  int           left[N];
  logic [N-1:0] m_en, m_ack;
  logic         m_wb;

  clk_gate_ctrl #(.N(N), .WAKE_CYCLES(WC), .IDLE_CYCLES(IC), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .BUSY     (BUSY),
    .FORCE_ON (FORCE_ON),
`ifdef CLK_GATE_CTRL_STATS_EN
    .STATS_CLR(STATS_CLR),
    .GATED_CNT(GATED_CNT),
`endif
    .CLK_EN   (CLK_EN),
    .ACK      (ACK),
    .WAKE_BUSY(WAKE_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ph[i] = P_OFF;
      left[i] = 0;
`ifdef CLK_GATE_CTRL_STATS_EN
      m_gc[i] = 0;
`endif
    end
    m_en = '0;
    m_ack = '0;
    m_wb = 1'b0;
  endtask

  task automatic model_step();
    int nph[N];
    int nleft[N];
    logic [N-1:0] nack;
    int  g;
    bit  free;
`ifdef CLK_GATE_CTRL_STATS_EN
    for (int i = 0; i < N; i++)
      if (STATS_CLR) m_gc[i] = 0;
      else if (!m_en[i] && m_gc[i] < 65535) m_gc[i]++;
`endif
    free = 1;
    for (int i = 0; i < N; i++) if (ph[i] == P_WAKE && left[i] > 1) free = 0;
    g = -1;
    if (free)
      for (int i = 0; i < N; i++)
        if (g < 0 && ph[i] == P_PEND && (REQ[i] || FORCE_ON)) g = i;
    nack = '0;
    for (int i = 0; i < N; i++) begin
      nph[i] = ph[i];
      nleft[i] = left[i];
      case (ph[i])
        P_OFF:  if (REQ[i]) nph[i] = P_PEND;
        P_PEND: if (i == g) begin nph[i] = P_WAKE; nleft[i] = WC; end
                else if (!REQ[i] && !FORCE_ON) nph[i] = P_OFF;
        P_WAKE: if (left[i] == 1) begin nph[i] = P_ON; nack[i] = 1'b1; end
                else nleft[i] = left[i] - 1;
        P_ON:   if (!REQ[i] && !BUSY[i]) begin nph[i] = P_IDLE; nleft[i] = IC; end
                else nack[i] = REQ[i];
        default: begin
          if (REQ[i]) begin nph[i] = P_ON; nack[i] = 1'b1; end
          else if (BUSY[i]) nph[i] = P_ON;
          else if (left[i] > 1) nleft[i] = left[i] - 1;
          else if (!FORCE_ON) nph[i] = P_OFF;
        end
      endcase
    end
    m_wb = 1'b0;
    for (int i = 0; i < N; i++) begin
      ph[i] = nph[i];
      left[i] = nleft[i];
      m_en[i] = FORCE_ON || (ph[i] != P_OFF && ph[i] != P_PEND);
      m_ack[i] = FORCE_ON ? REQ[i] : nack[i];
      if (ph[i] == P_WAKE) m_wb = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    REQ = '0;
    BUSY = '0;
    FORCE_ON = 1'b0;
`ifdef CLK_GATE_CTRL_STATS_EN
    STATS_CLR = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    REQ = '1;
    BUSY = '0;
    FORCE_ON = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    tests_run++;
    if ({CLK_EN, ACK, WAKE_BUSY} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b ack=%b wb=%b, want all 0", CLK_EN, ACK, WAKE_BUSY);
    end
    RST = 1'b1;
    step();
    step();
    tests_run++;
    if (CLK_EN !== 4'b0001 || WAKE_BUSY !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_wake: got en=%b wb=%b, want en=0001 wb=1", CLK_EN, WAKE_BUSY);
    end
  endtask

  task automatic test_single_wake();
    logic [N-1:0] en_h[1:5];
    logic [N-1:0] ack_h[1:5];
    logic         wb_h[1:5];
    do_reset();
    step();
    REQ = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      step();
      en_h[k] = CLK_EN;
      ack_h[k] = ACK;
      wb_h[k] = WAKE_BUSY;
    end
    tests_run++;
    if (en_h[1] !== 4'b0000) begin
      fails++; $display("FAIL single_pend_en: got %b want 0000", en_h[1]);
    end
    tests_run++;
    if (en_h[2] !== 4'b0010 || wb_h[2] !== 1'b1) begin
      fails++; $display("FAIL single_wake_en: got en=%b wb=%b want en=0010 wb=1", en_h[2], wb_h[2]);
    end
    tests_run++;
    if (ack_h[3] !== 4'b0000) begin
      fails++; $display("FAIL single_early_ack: got %b want 0000", ack_h[3]);
    end
    tests_run++;
    if (ack_h[4] !== 4'b0010 || wb_h[4] !== 1'b0) begin
      fails++; $display("FAIL single_ack: got ack=%b wb=%b want ack=0010 wb=0", ack_h[4], wb_h[4]);
    end
  endtask

  task automatic test_simultaneous();
    int rise[N];
    bit en2_seen, wb_bad;
    logic wb_exp;
    do_reset();
    for (int i = 0; i < N; i++) rise[i] = -1;
    en2_seen = 0;
    wb_bad = 0;
    REQ = 4'b1011;
    for (int k = 1; k <= 12; k++) begin
      step();
      for (int i = 0; i < N; i++) if (rise[i] < 0 && ACK[i] === 1'b1) rise[i] = k;
      if (CLK_EN[2] !== 1'b0) en2_seen = 1;
      // three back-to-back 2-cycle wakes occupy cycles 2..7
      wb_exp = (k >= 2 && k <= 7);
      if (WAKE_BUSY !== wb_exp) wb_bad = 1;
    end
    tests_run++;
    if (rise[0] != 4 || rise[1] != 6 || rise[3] != 8) begin
      fails++;
      $display("FAIL simul_ack_order: got rises %0d,%0d,%0d want 4,6,8", rise[0], rise[1], rise[3]);
    end
    tests_run++;
    if (en2_seen) begin
      fails++; $display("FAIL simul_en2: CLK_EN[2] rose, want 0 throughout");
    end
    tests_run++;
    if (wb_bad) begin
      fails++; $display("FAIL simul_wake_busy: WAKE_BUSY deviated from high on cycles 2..7 only");
    end
  endtask

  task automatic test_idle_gating();
    int n;
    do_reset();
    REQ = 4'b0001;
    repeat (6) step();
    REQ = 4'b0000;
    step();
    tests_run++;
    if (ACK[0] !== 1'b0 || CLK_EN[0] !== 1'b1) begin
      fails++; $display("FAIL idle_ack_drop: got ack=%b en=%b want ack=0 en=1", ACK[0], CLK_EN[0]);
    end
    n = 1;
    while (CLK_EN[0] === 1'b1 && n < 30) begin step(); n++; end
    tests_run++;
    if (n != 9) begin
      fails++; $display("FAIL idle_gate_delay: CLK_EN fell %0d cycles after REQ drop, want 9", n);
    end
  endtask

  task automatic test_idle_rewake();
    bit dropped;
    do_reset();
    REQ = 4'b0001;
    repeat (6) step();
    REQ = 4'b0000;
    dropped = 0;
    repeat (5) begin step(); if (CLK_EN[0] !== 1'b1) dropped = 1; end
    REQ = 4'b0001;
    step();
    tests_run++;
    if (ACK[0] !== 1'b1) begin
      fails++; $display("FAIL rewake_ack: got %b want 1", ACK[0]);
    end
    repeat (15) begin step(); if (CLK_EN[0] !== 1'b1) dropped = 1; end
    tests_run++;
    if (dropped) begin
      fails++; $display("FAIL rewake_en_hold: CLK_EN[0] dropped, want held 1");
    end
  endtask

  task automatic test_busy_hold();
    bit dropped;
    int n;
    do_reset();
    REQ = 4'b0100;
    repeat (6) step();
    REQ = 4'b0000;
    BUSY = 4'b0100;
    dropped = 0;
    repeat (20) begin step(); if (CLK_EN[2] !== 1'b1) dropped = 1; end
    tests_run++;
    if (dropped || ACK[2] !== 1'b0) begin
      fails++; $display("FAIL busy_hold: dropped=%0d ack=%b want dropped=0 ack=0", dropped, ACK[2]);
    end
    BUSY = 4'b0000;
    n = 0;
    do begin step(); n++; end while (CLK_EN[2] === 1'b1 && n < 30);
    // one cycle to enter IDLE_WAIT, then IDLE_CYCLES of hysteresis
    tests_run++;
    if (n != 1 + IC) begin
      fails++; $display("FAIL busy_release_gap: CLK_EN fell after %0d cycles, want %0d", n, 1 + IC);
    end
  endtask

  task automatic test_force_on();
    do_reset();
    FORCE_ON = 1'b1;
    step();
    step();
    tests_run++;
    if (CLK_EN !== 4'hF || ACK !== 4'h0) begin
      fails++; $display("FAIL force_idle: got en=%b ack=%b want en=1111 ack=0000", CLK_EN, ACK);
    end
    REQ = 4'b0101;
    step();
    tests_run++;
    if (CLK_EN !== 4'hF || ACK !== 4'b0101) begin
      fails++; $display("FAIL force_ack: got en=%b ack=%b want en=1111 ack=0101", CLK_EN, ACK);
    end
    FORCE_ON = 1'b0;
    REQ = 4'b0000;
    repeat (3) begin
      step();
      tests_run++;
      if (CLK_EN !== m_en || ACK !== m_ack || WAKE_BUSY !== m_wb) begin
        fails++;
        $display("FAIL force_release: got en=%b ack=%b wb=%b want en=%b ack=%b wb=%b",
                 CLK_EN, ACK, WAKE_BUSY, m_en, m_ack, m_wb);
      end
    end
  endtask

  task automatic test_reset_mid_wake();
    do_reset();
    REQ = 4'b0001;
    step();
    step();
    tests_run++;
    if (WAKE_BUSY !== 1'b1 || CLK_EN !== 4'b0001) begin
      fails++; $display("FAIL midwake_setup: got en=%b wb=%b want en=0001 wb=1", CLK_EN, WAKE_BUSY);
    end
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if ({CLK_EN, ACK, WAKE_BUSY} !== '0) begin
      fails++; $display("FAIL midwake_reset: got en=%b ack=%b wb=%b want all 0", CLK_EN, ACK, WAKE_BUSY);
    end
`ifdef CLK_GATE_CTRL_STATS_EN
    tests_run++;
    if (GATED_CNT !== '0) begin
      fails++; $display("FAIL midwake_stats: got %h want 0", GATED_CNT);
    end
`endif
    REQ = '0;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    repeat (600) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) REQ[i] = ~REQ[i];
        if ($urandom_range(5) == 0) BUSY[i] = ~BUSY[i];
      end
      if ($urandom_range(40) == 0) FORCE_ON = ~FORCE_ON;
`ifdef CLK_GATE_CTRL_STATS_EN
      STATS_CLR = ($urandom_range(63) == 0);
`endif
      step();
      tests_run++;
      if (CLK_EN !== m_en || ACK !== m_ack || WAKE_BUSY !== m_wb) begin
        fails++;
        if (fails < 20)
          $display("FAIL random_outputs: got en=%b ack=%b wb=%b want en=%b ack=%b wb=%b",
                   CLK_EN, ACK, WAKE_BUSY, m_en, m_ack, m_wb);
      end
`ifdef CLK_GATE_CTRL_STATS_EN
      for (int i = 0; i < N; i++) begin
        tests_run++;
        if (GATED_CNT[i*16 +: 16] !== 16'(m_gc[i])) begin
          fails++;
          if (fails < 20)
            $display("FAIL random_stats[%0d]: got %0d want %0d", i, GATED_CNT[i*16 +: 16], m_gc[i]);
        end
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, fails + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_wake();
    test_simultaneous();
    test_idle_gating();
    test_idle_rewake();
    test_busy_hold();
    test_force_on();
    test_reset_mid_wake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
